// File: rtl/sdram_copy_sequencer.sv
// Avalon-MM burst copy engine for the FPGA-side SDRAM controller.
// Reads up to BURST words into a local buffer, writes them back to the
// destination, repeats until the requested length is copied, and keeps a
// running 32-bit sum of every word read.
module sdram_copy_sequencer #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 16,
  parameter int BURST  = 8,
  parameter int LEN_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     src_addr,
  input  logic [ADDR_W-1:0]     dst_addr,
  input  logic [LEN_W-1:0]      len,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           checksum,
  output logic [ADDR_W-1:0]     avm_address,
  output logic [6:0]            avm_burstcount,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [DATA_W-1:0]     avm_writedata,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_readdatavalid,
  input  logic                  avm_waitrequest
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic [2:0] {IDLE, RD_CMD, RD_DATA, WR_BURST, DONE} state_t;

  state_t              state, state_nxt;
  logic                start_q;
  logic                start_edge;
  logic [ADDR_W-1:0]   rd_ptr, wr_ptr;
  logic [ADDR_W-1:0]   step;
  logic [LEN_W-1:0]    remaining;
  logic [LEN_W-1:0]    rem_next;
  logic [6:0]          beats;
  logic [6:0]          beat_idx;
  logic                rd_beat, wr_beat, last_beat;
  logic [DATA_W-1:0]   buffer [BURST];

  // Size of the next burst: a full BURST unless fewer words remain.
  function automatic logic [6:0] burst_beats(input logic [LEN_W-1:0] rem);
    if (rem >= LEN_W'(BURST)) return 7'(BURST);
    else                      return 7'(rem);
  endfunction

  assign start_edge     = start & ~start_q;
  assign rd_beat        = (state == RD_DATA) & avm_readdatavalid;
  assign wr_beat        = (state == WR_BURST) & ~avm_waitrequest;
  assign last_beat      = (beat_idx == beats - 7'd1);
  assign step           = ADDR_W'(beats) * ADDR_W'(BYTES);
  assign rem_next       = remaining - LEN_W'(beats);
  assign avm_byteenable = '1;

  // State register; reset aborts a copy at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and bus outputs, decoded purely from state so that
  // an asynchronous reset drops read/write without waiting for a clock.
  always_comb begin
    state_nxt      = state;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_burstcount = '0;
    avm_writedata  = '0;
    case (state)
      IDLE: begin
        if (start_edge) state_nxt = (len == '0) ? DONE : RD_CMD;
      end
      RD_CMD: begin
        avm_read       = 1'b1;
        avm_address    = rd_ptr;
        avm_burstcount = beats;
        if (!avm_waitrequest) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        if (rd_beat && last_beat) state_nxt = WR_BURST;
      end
      WR_BURST: begin
        avm_write      = 1'b1;
        avm_address    = wr_ptr;
        avm_burstcount = beats;
        avm_writedata  = buffer[beat_idx[IDX_W-1:0]];
        if (wr_beat && last_beat) state_nxt = (rem_next == '0) ? DONE : RD_CMD;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working registers: pointers, counts, status flags and checksum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      remaining <= '0;
      beats     <= '0;
      beat_idx  <= '0;
    end else begin
      start_q <= start;
      case (state)
        IDLE: begin
          if (start_edge) begin
            rd_ptr    <= src_addr;
            wr_ptr    <= dst_addr;
            remaining <= len;
            beats     <= burst_beats(len);
            beat_idx  <= '0;
            done      <= 1'b0;
            checksum  <= '0;
            busy      <= 1'b1;
          end
        end
        RD_DATA: begin
          if (rd_beat) begin
            checksum <= checksum + 32'(avm_readdata);
            beat_idx <= last_beat ? 7'd0 : beat_idx + 7'd1;
          end
        end
        WR_BURST: begin
          if (wr_beat) begin
            if (last_beat) begin
              beat_idx  <= '0;
              rd_ptr    <= rd_ptr + step;
              wr_ptr    <= wr_ptr + step;
              remaining <= rem_next;
              beats     <= burst_beats(rem_next);
            end else begin
              beat_idx <= beat_idx + 7'd1;
            end
          end
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Burst buffer: data only, never reset.
  always_ff @(posedge clk) begin
    if (rd_beat) buffer[beat_idx[IDX_W-1:0]] <= avm_readdata;
  end

endmodule

// File: doc/sdram_copy_sequencer.md
Name: sdram_copy_sequencer

Overview:
- Avalon-MM master that sequences block copies through the FPGA-side SDRAM controller (16-bit SDRAM) under HPS control.
- The HPS programs source, destination and length, then raises start (startsig PIO). The block reads SDRAM in bursts into a local buffer and writes each burst back to the destination.
- It keeps a running 32-bit checksum of copied words and raises done (donesig PIO) on completion.

Parameters:
- ADDR_W, 32, Avalon byte-address width.
- DATA_W, 16, data width; matches the SDRAM wire. Must be a multiple of 8.
- BURST, 8, maximum beats per burst. Power of 2, 1..64.
- LEN_W, 16, width of the word-count register.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  LEN_W? no: 1  level from HPS PIO; a rising edge launches a copy.
- src_addr  in  ADDR_W  source byte address; must be DATA_W/8 aligned.
- dst_addr  in  ADDR_W  destination byte address; must be DATA_W/8 aligned.
- len  in  LEN_W  number of DATA_W words to copy.
- busy  out  1  copy in progress.
- done  out  1  copy complete; sticky.
- checksum  out  32  sum of all words read, mod 2^32.
- avm_address  out  ADDR_W  Avalon address.
- avm_burstcount  out  7  beats in the current burst.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_writedata  out  DATA_W  write beat data.
- avm_byteenable  out  DATA_W/8  always all ones.
- avm_readdata  in  DATA_W  read beat data.
- avm_readdatavalid  in  1  read beat valid.
- avm_waitrequest  in  1  slave stall.

Behaviour:
- Reset values: busy=0, done=0, checksum=0, avm_read=0, avm_write=0, avm_address=0, avm_burstcount=0, avm_writedata=0. FSM goes to IDLE.
- Reset mid-operation aborts the copy immediately and asynchronously. Buffered data is discarded.
- Start detect: start is registered once; a rising edge is start & ~start_q.
  - In IDLE, the edge captures src_addr, dst_addr and len into working registers, clears done and checksum, and sets busy on the next cycle.
  - Edges while busy are ignored.
- States: IDLE, RD_CMD, RD_DATA, WR_BURST, DONE.
- IDLE -> RD_CMD on start edge with len != 0.
- IDLE -> DONE on start edge with len == 0. done rises 2 cycles after the edge; no bus traffic occurs.
- Burst size: beats = min(BURST, remaining words), latched on entry to RD_CMD.
- RD_CMD:
  - Drive avm_read=1, avm_address=rd_ptr, avm_burstcount=beats.
  - Hold all three stable until the cycle with avm_waitrequest=0, then go to RD_DATA and deassert read.
- RD_DATA:
  - Each cycle with avm_readdatavalid=1 stores avm_readdata into buffer[beat_idx], adds it (zero-extended) to checksum, and increments beat_idx.
  - After the beats-th beat, go to WR_BURST with beat_idx=0.
  - readdatavalid outside RD_DATA is ignored.
- WR_BURST:
  - Drive avm_write=1, avm_writedata=buffer[beat_idx], avm_burstcount=beats.
  - avm_address=wr_ptr is held constant for the whole burst.
  - A beat completes on write & ~waitrequest, which advances beat_idx. write stays high between beats; there are no idle gaps.
  - After the last beat: rd_ptr += beats*DATA_W/8, wr_ptr += beats*DATA_W/8, remaining -= beats.
  - If remaining == 0, go to DONE; otherwise go to RD_CMD.
- DONE: done=1, busy=0, return to IDLE the same cycle. done stays 1 until the next accepted start edge.
- Buffer: BURST x DATA_W register array. No read/write overlap, so a full/empty conflict cannot occur.
- Address arithmetic is modulo 2^ADDR_W. Wrap past the top of the address space is allowed and not flagged.
- A burst never exceeds BURST beats. The final partial burst uses the remaining count, e.g. len=19, BURST=8 gives bursts of 8, 8, 3.
- Overlapping src/dst ranges are not protected against. The result is defined only if dst <= src or the ranges are disjoint.
- checksum is valid while done=1 and is held until the next start.

Test Plan:
- len=16, BURST=8, src=0x0000 holding words 1..16, dst=0x1000, zero-wait slave -> two read bursts at 0x0000 and 0x0010 (burstcount 8), two write bursts at 0x1000 and 0x1010; dst holds 1..16; checksum=136; done=1.
- len=19 -> bursts of 8, 8, 3 on both read and write; the third read address is src+0x20; the memory image matches.
- Random waitrequest (50%) on command and write beats, plus 0–5 cycle readdatavalid gaps -> address and burstcount held stable while stalled; each beat written exactly once; checksum and data unchanged versus the zero-wait run.
- len=0 -> no avm_read or avm_write ever asserted; done=1 two cycles after the start edge; checksum=0.
- Second start edge during busy, and start held high after done -> ignored; exactly one copy performed. Lowering start then raising it again launches a new copy and clears done.
- reset asserted in the middle of WR_BURST (beat 3 of 8) -> avm_write, busy and done drop to 0 with no clock edge needed; a new start after reset release performs a full, correct copy.
